pll_lock_supervisor: RTL and testbench

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

---
 rtl/pll_lock_supervisor.sv | 235 +++++++++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// pll_lock_supervisor
//
// Purpose:
//   Sequences a PLL out of reset and generates a clean reset/ready pair for
//   the logic that runs from the PLL output clocks. The PLL is held in reset
//   for a fixed pulse, the supervisor then waits for lock. The lock has to
//   stay up for a programmable number of cycles before the downstream
//   reset is released. Any lock loss while running re-pulses the PLL reset
//   and is counted in a saturating 8-bit counter.
//
//   Optional feature (compile-time macro PLL_SUP_TIMEOUT_EN):
//     defined   - if lock is not seen within RESTART_TIMEOUT cycles of
//                 WAIT_LOCK, the PLL is reset again (no loss counted).
//     undefined - WAIT_LOCK waits indefinitely; no timeout counter exists.
//
// Parameters:
//   STABLE_CYCLES   - consecutive synchronized-lock cycles before release
//   PLL_RST_CYCLES  - width of each PLL reset pulse in clk cycles
//   RESTART_TIMEOUT - WAIT_LOCK cycles before a restart (macro builds only)
//
// Ports:
//   clk         in   free-running reference clock (also the PLL refclk)
//   nrst        in   asynchronous active-low reset
//   locked      in   PLL lock flag, asynchronous to clk
//   clear_count in   synchronous request to zero loss_count
//   pll_rst     out  active-high PLL reset (registered)
//   sys_nrst    out  active-low reset for PLL-clocked logic (registered)
//   ready       out  high while the PLL is locked and stable (registered)
//   loss_count  out  saturating count of lock losses seen in RUN
// ---------------------------------------------------------------------------
module pll_lock_supervisor #(
    parameter int STABLE_CYCLES   = 1024,
    parameter int PLL_RST_CYCLES  = 16,
    parameter int RESTART_TIMEOUT = 65535
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       locked,
    input  logic       clear_count,
    output logic       pll_rst,
    output logic       sys_nrst,
    output logic       ready,
    output logic [7:0] loss_count
);

    // Counter widths leave one bit of headroom above the terminal value.
    localparam int STAB_W = $clog2(STABLE_CYCLES) + 1;
    localparam int RST_W  = $clog2(PLL_RST_CYCLES) + 1;

    // Terminal values: a counter that starts at 0 on entry and stops at
    // N-1 spans exactly N edges in its state.
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(PLL_RST_CYCLES - 1);
    localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);
    localparam logic [RST_W-1:0]  RST_ONE   = RST_W'(1);

`ifdef PLL_SUP_TIMEOUT_EN
    localparam int TO_W = $clog2(RESTART_TIMEOUT) + 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(RESTART_TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
`endif

    typedef enum logic [1:0] {
        ST_PLL_RESET = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABILIZE = 2'd2,
        ST_RUN       = 2'd3
    } state_e;

    // -----------------------------------------------------------------------
    // Lock synchronizer: locked is asynchronous, so only the second flop
    // (locked_s) is allowed to reach the FSM.
    // -----------------------------------------------------------------------
    logic [1:0] sync_q;
    logic       locked_s;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], locked};
        end
    end

    assign locked_s = sync_q[1];

    // -----------------------------------------------------------------------
    // State, counters and registered outputs
    // -----------------------------------------------------------------------
    state_e            state_q,    state_d;
    logic [RST_W-1:0]  rst_cnt_q,  rst_cnt_d;
    logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
    logic [7:0]        loss_q,     loss_d;
    logic              pll_rst_q,  pll_rst_d;
    logic              sys_nrst_q, sys_nrst_d;
    logic              ready_q,    ready_d;
    logic              loss_event;
`ifdef PLL_SUP_TIMEOUT_EN
    logic [TO_W-1:0]   to_cnt_q,   to_cnt_d;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= ST_PLL_RESET;
            rst_cnt_q  <= '0;
            stab_cnt_q <= '0;
            loss_q     <= '0;
            pll_rst_q  <= 1'b1;
            sys_nrst_q <= 1'b0;
            ready_q    <= 1'b0;
`ifdef PLL_SUP_TIMEOUT_EN
            to_cnt_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rst_cnt_q  <= rst_cnt_d;
            stab_cnt_q <= stab_cnt_d;
            loss_q     <= loss_d;
            pll_rst_q  <= pll_rst_d;
            sys_nrst_q <= sys_nrst_d;
            ready_q    <= ready_d;
`ifdef PLL_SUP_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        rst_cnt_d  = rst_cnt_q;
        stab_cnt_d = stab_cnt_q;
        loss_event = 1'b0;
`ifdef PLL_SUP_TIMEOUT_EN
        to_cnt_d   = to_cnt_q;
`endif

        case (state_q)
            ST_PLL_RESET: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d   = ST_WAIT_LOCK;
                    rst_cnt_d = '0;
`ifdef PLL_SUP_TIMEOUT_EN
                    to_cnt_d  = '0;
`endif
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_ONE;
                end
            end

            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d    = ST_STABILIZE;
                    stab_cnt_d = '0;
                end
`ifdef PLL_SUP_TIMEOUT_EN
                // Lock never arrived: pulse the PLL again. This is not a
                // loss of an established lock, so loss_count is untouched.
                else if (to_cnt_q == TO_LAST) begin
                    state_d   = ST_PLL_RESET;
                    rst_cnt_d = '0;
                    to_cnt_d  = '0;
                end else begin
                    to_cnt_d = to_cnt_q + TO_ONE;
                end
`endif
            end

            ST_STABILIZE: begin
                if (!locked_s) begin
                    // Lock bounced before it was trusted: go back and wait
                    // for it again without counting a loss.
                    state_d = ST_WAIT_LOCK;
`ifdef PLL_SUP_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                end else if (stab_cnt_q == STAB_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    stab_cnt_d = stab_cnt_q + STAB_ONE;
                end
            end

            ST_RUN: begin
                if (!locked_s) begin
                    state_d    = ST_PLL_RESET;
                    rst_cnt_d  = '0;
                    loss_event = 1'b1;
                end
            end

            default: begin
                state_d   = ST_PLL_RESET;
                rst_cnt_d = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Loss counter. A clear that lands on the same edge as a loss keeps
    // that loss, so the counter restarts at 1 rather than 0.
    // -----------------------------------------------------------------------
    always_comb begin
        loss_d = loss_q;
        if (loss_event) begin
            if (clear_count) begin
                loss_d = 8'd1;
            end else if (loss_q != 8'hFF) begin
                loss_d = loss_q + 8'd1;
            end
        end else if (clear_count) begin
            loss_d = 8'd0;
        end
    end

    // -----------------------------------------------------------------------
    // Output decode from the next state, so the output flops switch on the
    // same edge as the state register and never glitch. sys_nrst therefore
    // drops on the very edge that leaves RUN.
    // -----------------------------------------------------------------------
    always_comb begin
        pll_rst_d  = (state_d == ST_PLL_RESET);
        sys_nrst_d = (state_d == ST_RUN);
        ready_d    = (state_d == ST_RUN);
    end

    assign pll_rst    = pll_rst_q;
    assign sys_nrst   = sys_nrst_q;
    assign ready      = ready_q;
    assign loss_count = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_supervisor
//
// Self-checking bench for pll_lock_supervisor with STABLE_CYCLES=8,
// PLL_RST_CYCLES=4, RESTART_TIMEOUT=20. Works for builds with and without
// PLL_SUP_TIMEOUT_EN. Outputs are sampled on the falling edge; inputs are
// driven on the falling edge as well.
// ---------------------------------------------------------------------------
module tb_pll_lock_supervisor;

    localparam int STABLE = 8;
    localparam int RSTC   = 4;
    localparam int TOUT   = 20;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       locked = 1'b0;
    logic       clear_count = 1'b0;
    logic       pll_rst;
    logic       sys_nrst;
    logic       ready;
    logic [7:0] loss_count;

    pll_lock_supervisor #(
        .STABLE_CYCLES   (STABLE),
        .PLL_RST_CYCLES  (RSTC),
        .RESTART_TIMEOUT (TOUT)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .locked      (locked),
        .clear_count (clear_count),
        .pll_rst     (pll_rst),
        .sys_nrst    (sys_nrst),
        .ready       (ready),
        .loss_count  (loss_count)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // -----------------------------------------------------------------------
    // Reference model: phase plus "edges spent" bookkeeping, derived from the
    // behavioural rules. The lock path is a plain two-sample delay.
    // -----------------------------------------------------------------------
    localparam int PH_RESET = 0;
    localparam int PH_WAIT  = 1;
    localparam int PH_STAB  = 2;
    localparam int PH_RUN   = 3;

    int m_phase;
    int m_elapsed;
    int m_run;
    int m_loss;
    bit m_s1;
    bit m_s2;

    function automatic void model_reset();
        m_phase   = PH_RESET;
        m_elapsed = 0;
        m_run     = 0;
        m_loss    = 0;
        m_s1      = 1'b0;
        m_s2      = 1'b0;
    endfunction

    function automatic bit model_loss_next();
        return (m_phase == PH_RUN) && !m_s2;
    endfunction

    function automatic void model_step(input bit lk, input bit clr);
        bit ls;
        bit loss_ev;
        ls      = m_s2;
        loss_ev = 1'b0;
        case (m_phase)
            PH_RESET: begin
                m_elapsed++;
                if (m_elapsed >= RSTC) begin
                    m_phase   = PH_WAIT;
                    m_elapsed = 0;
                end
            end
            PH_WAIT: begin
                if (ls) begin
                    m_phase = PH_STAB;
                    m_run   = 0;
                end else begin
                    m_elapsed++;
`ifdef PLL_SUP_TIMEOUT_EN
                    if (m_elapsed >= TOUT) begin
                        m_phase   = PH_RESET;
                        m_elapsed = 0;
                    end
`endif
                end
            end
            PH_STAB: begin
                if (!ls) begin
                    m_phase   = PH_WAIT;
                    m_elapsed = 0;
                end else begin
                    m_run++;
                    if (m_run >= STABLE) m_phase = PH_RUN;
                end
            end
            default: begin
                if (!ls) begin
                    m_phase   = PH_RESET;
                    m_elapsed = 0;
                    loss_ev   = 1'b1;
                end
            end
        endcase
        if (loss_ev) m_loss = clr ? 1 : ((m_loss < 255) ? m_loss + 1 : 255);
        else if (clr) m_loss = 0;
        m_s2 = m_s1;
        m_s1 = lk;
    endfunction

    function automatic logic [10:0] model_out();
        logic [7:0] l8;
        l8 = 8'(m_loss);
        return {(m_phase == PH_RESET), (m_phase == PH_RUN), (m_phase == PH_RUN), l8};
    endfunction

    function automatic logic [10:0] dut_out();
        return {pll_rst, sys_nrst, ready, loss_count};
    endfunction

    function automatic void check(input string what, input logic [10:0] got,
                                  input logic [10:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got pll_rst=%b sys_nrst=%b ready=%b loss=%0d, need pll_rst=%b sys_nrst=%b ready=%b loss=%0d",
                     what, got[10], got[9], got[8], got[7:0], exp[10], exp[9], exp[8], exp[7:0]);
        end
    endfunction

    function automatic void bound_expired(input string what);
        vectors++;
        miscompares++;
        $display("FAIL %s: cycle bound expired", what);
    endfunction

    // One clock: drive inputs, advance the model on the edge, sample at negedge.
    task automatic tick(input bit lk, input bit clr);
        locked      = lk;
        clear_count = clr;
        @(posedge clk);
        model_step(lk, clr);
        @(negedge clk);
    endtask

    task automatic tick_check(input string what, input bit lk, input bit clr);
        tick(lk, clr);
        check(what, dut_out(), model_out());
    endtask

    task automatic do_reset();
        @(negedge clk);
        nrst        = 1'b0;
        locked      = 1'b0;
        clear_count = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset-values", dut_out(), 11'b100_00000000);
        nrst = 1'b1;
    endtask

    // Drive locked high until RUN is reached (bounded).
    task automatic run_up(input string what);
        int guard;
        guard = 0;
        while (m_phase != PH_RUN && guard < 200) begin
            tick_check(what, 1'b1, 1'b0);
            guard++;
        end
        if (m_phase != PH_RUN) bound_expired(what);
    endtask

    typedef struct {
        logic        lk;
        logic        clr;
        int          n;
        logic [10:0] exp;
    } row_t;

    row_t tbl [16];

    initial begin : main
        bit exp_pll;
        int guard;

        // Rows are applied back-to-back from reset release (edge 1 onwards).
        // exp = {pll_rst, sys_nrst, ready, loss_count} after the last edge.
        tbl[0]  = '{1'b0, 1'b0,  3, 11'b100_00000000}; // edges 1-3: pulse on
        tbl[1]  = '{1'b0, 1'b0,  1, 11'b000_00000000}; // edge 4: pulse ends
        tbl[2]  = '{1'b0, 1'b0, 10, 11'b000_00000000}; // waiting for lock
        tbl[3]  = '{1'b1, 1'b0,  9, 11'b000_00000000}; // lock sampled edge 15
        tbl[4]  = '{1'b1, 1'b0,  1, 11'b000_00000000}; // edge 24: not yet
        tbl[5]  = '{1'b1, 1'b0,  1, 11'b011_00000000}; // edge 25: 10th edge
        tbl[6]  = '{1'b1, 1'b0,  5, 11'b011_00000000};
        tbl[7]  = '{1'b0, 1'b0,  2, 11'b011_00000000}; // loss in synchronizer
        tbl[8]  = '{1'b0, 1'b0,  1, 11'b100_00000001}; // 3rd edge: leave RUN
        tbl[9]  = '{1'b1, 1'b0,  3, 11'b100_00000001};
        tbl[10] = '{1'b1, 1'b0,  1, 11'b000_00000001}; // 4-cycle pulse done
        tbl[11] = '{1'b1, 1'b0,  1, 11'b000_00000001};
        tbl[12] = '{1'b1, 1'b0,  7, 11'b000_00000001};
        tbl[13] = '{1'b1, 1'b0,  1, 11'b011_00000001};
        tbl[14] = '{1'b1, 1'b1,  1, 11'b011_00000000}; // clear_count
        tbl[15] = '{1'b1, 1'b0,  1, 11'b011_00000000};

        // ---------------- table-driven sequence ----------------
        do_reset();
        for (int r = 0; r < 16; r++) begin
            for (int k = 0; k < tbl[r].n - 1; k++) begin
                tick_check("table-step", tbl[r].lk, tbl[r].clr);
            end
            tick(tbl[r].lk, tbl[r].clr);
            check($sformatf("table-row%0d", r), dut_out(), tbl[r].exp);
            $display("row %0d: locked=%b clr=%b n=%0d -> pll_rst=%b sys_nrst=%b ready=%b loss=%0d",
                     r, tbl[r].lk, tbl[r].clr, tbl[r].n, pll_rst, sys_nrst, ready, loss_count);
        end

        // ---------------- lock glitch during STABILIZE ----------------
        do_reset();
        repeat (10) tick_check("glitch-wait", 1'b0, 1'b0);
        repeat (5)  tick_check("glitch-high5", 1'b1, 1'b0);
        tick_check("glitch-low1", 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            tick(1'b1, 1'b0);
            check("glitch-no-early-run", dut_out(), 11'b000_00000000);
        end
        tick(1'b1, 1'b0);
        check("glitch-run-after-restart", dut_out(), 11'b011_00000000);
        $display("glitch: stability restart -> ready=%b loss=%0d", ready, loss_count);

        // ---------------- lock never arrives ----------------
        do_reset();
        for (int e = 1; e <= 60; e++) begin
            tick(1'b0, 1'b0);
`ifdef PLL_SUP_TIMEOUT_EN
            exp_pll = ((e % (RSTC + TOUT)) < RSTC);
`else
            exp_pll = (e < RSTC);
`endif
            check($sformatf("no-lock-edge%0d", e), dut_out(), {exp_pll, 10'b0});
        end
        $display("no-lock: 60 edges with locked=0 checked for restart pulses");

        // ---------------- randomized segments against the model ----------------
        for (int s = 0; s < 120; s++) begin
            bit lvl;
            int len;
            lvl = ($urandom_range(0, 3) != 0);
            len = lvl ? $urandom_range(1, 25) : $urandom_range(1, 4);
            if ($urandom_range(0, 9) == 0) begin
                lvl = 1'b0;
                len = 30;
            end
            for (int k = 0; k < len; k++) begin
                tick_check("random", lvl, ($urandom_range(0, 15) == 0));
            end
            $display("seg %0d: locked=%b len=%0d -> pll_rst=%b ready=%b loss=%0d",
                     s, lvl, len, pll_rst, ready, loss_count);
        end

        // ---------------- saturation then clear-with-loss ----------------
        do_reset();
        for (int i = 0; i < 256; i++) begin
            run_up("sat-runup");
            guard = 0;
            while (m_phase == PH_RUN && guard < 10) begin
                tick_check("sat-drop", 1'b0, 1'b0);
                guard++;
            end
            if (m_phase == PH_RUN) bound_expired("sat-drop");
            $display("loss %0d: loss_count=%0d", i + 1, loss_count);
        end
        check("sat-255", dut_out(), 11'b100_11111111);
        run_up("sat-runup257");
        check("sat-run-255", dut_out(), 11'b011_11111111);
        guard = 0;
        while (m_phase == PH_RUN && guard < 10) begin
            tick_check("sat-clear-drop", 1'b0, model_loss_next());
            guard++;
        end
        if (m_phase == PH_RUN) bound_expired("sat-clear-drop");
        check("clear-with-loss", dut_out(), 11'b100_00000001);
        $display("clear+loss: loss_count=%0d", loss_count);

        // ---------------- asynchronous reset from RUN ----------------
        run_up("async-runup");
        #2;
        nrst = 1'b0;
        #1;
        check("async-reset", dut_out(), 11'b100_00000000);
        model_reset();
        @(negedge clk);
        nrst = 1'b1;
        repeat (3) tick_check("post-async", 1'b0, 1'b0);
        $display("async reset: pll_rst=%b sys_nrst=%b ready=%b loss=%0d",
                 pll_rst, sys_nrst, ready, loss_count);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "time limit");
    end

endmodule
